ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 5-stage integer MIPS pipeline, between ID and MEM.
- Selects forwarded or register-file operands and performs ALU/shift/compare operations.
- Resolves branches and jumps, and computes load/store effective addresses.
- Registers all results into the EX/MEM pipeline register (one-cycle latency).

Parameters:
- none

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- opcode  in  6  instr[31:26]
- format  in  5  instr[25:21] COP format; unused, integer-only stage
- funct  in  6  instr[5:0]
- rs  in  5  source register index
- rt  in  5  target register index
- rd  in  5  destination register index
- imm  in  16  immediate
- offset  in  26  jump target field
- base  in  5  load/store base index (equals rs)
- sa  in  5  shift amount
- bltz  in  5  REGIMM rt field (00000 BLTZ, 00001 BGEZ)
- pc  in  32  address of this instruction
- i_type  in  2  00 R, 01 I, 10 J, 11 invalid
- rs_id  in  32  rs value from register file
- rt_id  in  32  rt value from register file
- rs_forward  in  32  forwarded rs value
- rt_forward  in  32  forwarded rt value
- is_forward_rs  in  1  select rs_forward
- is_forward_rt  in  1  select rt_forward
- halt_in  in  1  incoming instruction is halt/bubble
- halt_from_control  in  1  stall: hold EX/MEM register
- jump_address  out  32  taken branch/jump target
- is_int_wb  out  1  integer writeback enable
- is_jump  out  1  branch/jump taken
- is_mem  out  1  memory access (load or store)
- value_to_be_store  out  32  store data (rt operand)
- int_wb_address  out  6  {1'b0, dest reg}
- int_wb_value  out  32  ALU/link result
- effective_address  out  32  base + sext(imm)
- data_width  out  2  00 byte, 01 half, 10 word
- halt  out  1  registered halt_in

Behaviour:
Operand selection and register timing
- A = is_forward_rs ? rs_forward : rs_id; B = is_forward_rt ? rt_forward : rt_id.
- All outputs are registered on the rising clk edge.
- reset==0 at an edge clears every output to 0; reset has priority over stall.
- halt_from_control==1 holds every output unchanged.
- halt_in==1 or i_type==11: load a bubble (all enables 0, data 0) and set halt=halt_in.
- Unrecognised opcode/funct: bubble with halt=0.

R-type (opcode 0), wb dest rd
- ADD/ADDU: A+B. SUB/SUBU: A-B. No overflow trap; ADD/SUB behave as ADDU/SUBU.
- AND, OR, XOR: bitwise. NOR: ~(A|B).
- SLT: signed A<B, result 1/0. SLTU: unsigned A<B.
- SLL, SRL, SRA: shift B by sa.
- SLLV, SRLV, SRAV: shift B by A[4:0].
- JR: is_jump=1, jump_address=A, no writeback.
- JALR: is_jump=1, jump_address=A, writes pc+8 to rd.
- Writeback to register 0: is_int_wb=0.

I-type, wb dest rt
- ADDI/ADDIU: A+sext(imm). SLTI: signed compare with sext(imm). SLTIU: unsigned compare with sext(imm).
- ANDI, ORI, XORI: use zext(imm). LUI: {imm,16'h0}.

Branches (no writeback)
- Target = pc+4+(sext(imm)<<2).
- BEQ: A==B. BNE: A!=B. BLEZ: A<=0 signed. BGTZ: A>0 signed.
- BLTZ/BGEZ via opcode 01 with the bltz field.
- is_jump=1 only when taken; jump_address is 0 when not taken.

Jumps
- J/JAL target = {pc+4[31:28], offset, 2'b00}, is_jump=1.
- JAL writes pc+8 to register 31.

Memory
- effective_address = A+sext(imm).
- LB/LH/LW: is_mem=1, is_int_wb=1, dest rt, int_wb_value=0 (MEM stage substitutes data and sign-extends).
- SB/SH/SW: is_mem=1, is_int_wb=0, value_to_be_store=B.
- data_width: byte 00, half 01, word 10; 00 for non-memory instructions.

Simultaneous events
- reset > halt_from_control > halt_in > decode.

Test Plan:
- reset=0 for 1 cycle with ADDU inputs present -> all outputs 0; after reset=1, ADDU rs_id=5, rt_id=7, rd=3 -> int_wb_value=12, int_wb_address=6'd3, is_int_wb=1, one cycle later.
- Forwarding: is_forward_rs=1, rs_forward=100, rs_id=1, ADDIU imm=16'hFFFF -> int_wb_value=99.
- BEQ pc=10000, A=B=4, imm=3 -> is_jump=1, jump_address=10016; with A!=B -> is_jump=0.
- JAL pc=32'h00400000, offset=26'h10 -> jump_address=32'h00000040, int_wb_address=31, int_wb_value=32'h00400008.
- SW base value 10100, imm=-4, B=32'hDEADBEEF -> effective_address=10096, is_mem=1, is_int_wb=0, data_width=10, value_to_be_store=DEADBEEF; LB -> data_width=00, is_int_wb=1.
- Stall and halt: halt_from_control=1 for 2 cycles -> outputs frozen; halt_in=1 -> halt=1 and all enables 0; reset asserted together with halt_from_control -> outputs cleared.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage integer MIPS pipeline (ID -> EX -> MEM).
// Picks forwarded or register-file operands, runs ALU/shift/compare ops,
// resolves branches and jumps, forms load/store effective addresses and
// registers everything into the EX/MEM pipeline register (1-cycle latency).
//
// Ports:
//   clk, reset             rising-edge clock, synchronous active-low reset
//   opcode/format/funct    instruction fields (format unused: integer-only stage)
//   rs/rt/rd/base/sa/bltz  register indices, shift amount, REGIMM selector
//   imm, offset            16-bit immediate, 26-bit jump target field
//   pc                     address of this instruction
//   i_type                 00 R, 01 I, 10 J, 11 invalid
//   rs_id/rt_id            register-file operands
//   rs_forward/rt_forward  forwarded operands, selected by is_forward_rs/rt
//   halt_in                incoming halt/bubble
//   halt_from_control      stall: EX/MEM register holds its value
//   outputs                registered EX/MEM fields (jump, writeback, memory, halt)
module ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [4:0]  format,
  input  logic [5:0]  funct,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] offset,
  input  logic [4:0]  base,
  input  logic [4:0]  sa,
  input  logic [4:0]  bltz,
  input  logic [31:0] pc,
  input  logic [1:0]  i_type,
  input  logic [31:0] rs_id,
  input  logic [31:0] rt_id,
  input  logic [31:0] rs_forward,
  input  logic [31:0] rt_forward,
  input  logic        is_forward_rs,
  input  logic        is_forward_rt,
  input  logic        halt_in,
  input  logic        halt_from_control,
  output logic [31:0] jump_address,
  output logic        is_int_wb,
  output logic        is_jump,
  output logic        is_mem,
  output logic [31:0] value_to_be_store,
  output logic [5:0]  int_wb_address,
  output logic [31:0] int_wb_value,
  output logic [31:0] effective_address,
  output logic [1:0]  data_width,
  output logic        halt
);

  typedef enum logic [5:0] {
    OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02, OP_JAL   = 6'h03,
    OP_BEQ     = 6'h04, OP_BNE    = 6'h05, OP_BLEZ  = 6'h06, OP_BGTZ  = 6'h07,
    OP_ADDI    = 6'h08, OP_ADDIU  = 6'h09, OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B,
    OP_ANDI    = 6'h0C, OP_ORI    = 6'h0D, OP_XORI  = 6'h0E, OP_LUI   = 6'h0F,
    OP_LB      = 6'h20, OP_LH     = 6'h21, OP_LW    = 6'h23,
    OP_SB      = 6'h28, OP_SH     = 6'h29, OP_SW    = 6'h2B
  } opcode_e;

  typedef enum logic [5:0] {
    FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03, FN_SLLV = 6'h04,
    FN_SRLV = 6'h06, FN_SRAV = 6'h07, FN_JR   = 6'h08, FN_JALR = 6'h09,
    FN_ADD  = 6'h20, FN_ADDU = 6'h21, FN_SUB  = 6'h22, FN_SUBU = 6'h23,
    FN_AND  = 6'h24, FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_NOR  = 6'h27,
    FN_SLT  = 6'h2A, FN_SLTU = 6'h2B
  } funct_e;

  // base always equals rs and format is meaningless here; rs is only
  // consumed through the already-read operand values.
  logic unused_ok;
  assign unused_ok = ^{format, rs, base};

  logic [31:0] a, b, sext_imm, zext_imm, pc4, pc8, br_target, mem_addr;

  assign a         = is_forward_rs ? rs_forward : rs_id;
  assign b         = is_forward_rt ? rt_forward : rt_id;
  assign sext_imm  = {{16{imm[15]}}, imm};
  assign zext_imm  = {16'h0000, imm};
  assign pc4       = pc + 32'd4;
  assign pc8       = pc + 32'd8;
  assign br_target = pc4 + {sext_imm[29:0], 2'b00};
  assign mem_addr  = a + sext_imm;

  logic        n_jump, n_mem, n_wb, n_valid, n_taken, n_halt;
  logic [4:0]  n_dest;
  logic [31:0] n_jaddr, n_val, n_store, n_ea;
  logic [1:0]  n_width;

  always_comb begin
    n_jump  = 1'b0;
    n_mem   = 1'b0;
    n_wb    = 1'b0;
    n_valid = 1'b1;
    n_taken = 1'b0;
    n_dest  = '0;
    n_jaddr = '0;
    n_val   = '0;
    n_store = '0;
    n_ea    = '0;
    n_width = '0;
    n_halt  = halt_in;

    if (halt_in || i_type == 2'b11) begin
      n_valid = 1'b0;
    end else begin
      unique case (opcode)
        OP_SPECIAL: begin
          n_wb   = 1'b1;
          n_dest = rd;
          case (funct)
            FN_ADD, FN_ADDU: n_val = a + b;
            FN_SUB, FN_SUBU: n_val = a - b;
            FN_AND:  n_val = a & b;
            FN_OR:   n_val = a | b;
            FN_XOR:  n_val = a ^ b;
            FN_NOR:  n_val = ~(a | b);
            FN_SLT:  n_val = {31'd0, $signed(a) < $signed(b)};
            FN_SLTU: n_val = {31'd0, a < b};
            FN_SLL:  n_val = b << sa;
            FN_SRL:  n_val = b >> sa;
            FN_SRA:  n_val = $signed(b) >>> sa;
            FN_SLLV: n_val = b << a[4:0];
            FN_SRLV: n_val = b >> a[4:0];
            FN_SRAV: n_val = $signed(b) >>> a[4:0];
            FN_JR: begin
              n_wb    = 1'b0;
              n_jump  = 1'b1;
              n_jaddr = a;
            end
            FN_JALR: begin
              n_jump  = 1'b1;
              n_jaddr = a;
              n_val   = pc8;
            end
            default: n_valid = 1'b0;
          endcase
        end
        OP_REGIMM: begin
          if (bltz == 5'd0)      n_taken = a[31];
          else if (bltz == 5'd1) n_taken = !a[31];
          else                   n_valid = 1'b0;
        end
        OP_BEQ:  n_taken = (a == b);
        OP_BNE:  n_taken = (a != b);
        OP_BLEZ: n_taken = a[31] || (a == '0);
        OP_BGTZ: n_taken = !a[31] && (a != '0);
        OP_J, OP_JAL: begin
          n_jump  = 1'b1;
          n_jaddr = {pc4[31:28], offset, 2'b00};
          if (opcode == OP_JAL) begin
            n_wb   = 1'b1;
            n_dest = 5'd31;
            n_val  = pc8;
          end
        end
        OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
        OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
          n_wb   = 1'b1;
          n_dest = rt;
          case (opcode)
            OP_SLTI:  n_val = {31'd0, $signed(a) < $signed(sext_imm)};
            OP_SLTIU: n_val = {31'd0, a < sext_imm};
            OP_ANDI:  n_val = a & zext_imm;
            OP_ORI:   n_val = a | zext_imm;
            OP_XORI:  n_val = a ^ zext_imm;
            OP_LUI:   n_val = {imm, 16'h0000};
            default:  n_val = a + sext_imm;
          endcase
        end
        OP_LB, OP_LH, OP_LW: begin
          // Load data arrives in MEM; only the destination is booked here.
          n_mem   = 1'b1;
          n_wb    = 1'b1;
          n_dest  = rt;
          n_ea    = mem_addr;
          n_width = (opcode == OP_LB) ? 2'b00 : (opcode == OP_LH) ? 2'b01 : 2'b10;
        end
        OP_SB, OP_SH, OP_SW: begin
          n_mem   = 1'b1;
          n_ea    = mem_addr;
          n_store = b;
          n_width = (opcode == OP_SB) ? 2'b00 : (opcode == OP_SH) ? 2'b01 : 2'b10;
        end
        default: n_valid = 1'b0;
      endcase

      if (n_taken) begin
        n_jump  = 1'b1;
        n_jaddr = br_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      jump_address      <= '0;
      is_int_wb         <= 1'b0;
      is_jump           <= 1'b0;
      is_mem            <= 1'b0;
      value_to_be_store <= '0;
      int_wb_address    <= '0;
      int_wb_value      <= '0;
      effective_address <= '0;
      data_width        <= '0;
      halt              <= 1'b0;
    end else if (!halt_from_control) begin
      if (!n_valid) begin
        jump_address      <= '0;
        is_int_wb         <= 1'b0;
        is_jump           <= 1'b0;
        is_mem            <= 1'b0;
        value_to_be_store <= '0;
        int_wb_address    <= '0;
        int_wb_value      <= '0;
        effective_address <= '0;
        data_width        <= '0;
        halt              <= n_halt;
      end else begin
        jump_address      <= n_jaddr;
        is_int_wb         <= n_wb && (n_dest != 5'd0);
        is_jump           <= n_jump;
        is_mem            <= n_mem;
        value_to_be_store <= n_store;
        int_wb_address    <= n_wb ? {1'b0, n_dest} : 6'd0;
        int_wb_value      <= n_wb ? n_val : 32'd0;
        effective_address <= n_ea;
        data_width        <= n_width;
        halt              <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage: directed cases with literal expectations, then
// randomized instructions checked every cycle against an instruction-level model.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic [4:0]  format;
  logic [5:0]  funct;
  logic [4:0]  rs, rt, rd, base, sa, bltz;
  logic [15:0] imm;
  logic [25:0] offset;
  logic [31:0] pc;
  logic [1:0]  i_type;
  logic [31:0] rs_id, rt_id, rs_forward, rt_forward;
  logic        is_forward_rs, is_forward_rt, halt_in, halt_from_control;
  logic [31:0] jump_address, value_to_be_store, int_wb_value, effective_address;
  logic        is_int_wb, is_jump, is_mem, halt;
  logic [5:0]  int_wb_address;
  logic [1:0]  data_width;

  ex_stage dut (
    .clk(clk), .reset(reset), .opcode(opcode), .format(format), .funct(funct),
    .rs(rs), .rt(rt), .rd(rd), .imm(imm), .offset(offset), .base(base), .sa(sa),
    .bltz(bltz), .pc(pc), .i_type(i_type), .rs_id(rs_id), .rt_id(rt_id),
    .rs_forward(rs_forward), .rt_forward(rt_forward),
    .is_forward_rs(is_forward_rs), .is_forward_rt(is_forward_rt),
    .halt_in(halt_in), .halt_from_control(halt_from_control),
    .jump_address(jump_address), .is_int_wb(is_int_wb), .is_jump(is_jump),
    .is_mem(is_mem), .value_to_be_store(value_to_be_store),
    .int_wb_address(int_wb_address), .int_wb_value(int_wb_value),
    .effective_address(effective_address), .data_width(data_width), .halt(halt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] jump_address;
    logic        is_int_wb;
    logic        is_jump;
    logic        is_mem;
    logic [31:0] value_to_be_store;
    logic [5:0]  int_wb_address;
    logic [31:0] int_wb_value;
    logic [31:0] effective_address;
    logic [1:0]  data_width;
    logic        halt;
  } out_t;

  out_t dut_o, exp_o;
  assign dut_o = {jump_address, is_int_wb, is_jump, is_mem, value_to_be_store,
                  int_wb_address, int_wb_value, effective_address, data_width, halt};

  int n_checks = 0;
  int n_fails  = 0;
  bit check_en = 1'b0;

  // What one instruction must produce, straight from the ISA semantics.
  function automatic out_t ref_model();
    out_t        o;
    logic [31:0] a, b, sx, zx, v, pc4;
    logic [4:0]  dst;
    bit          wb, ok;
    o   = '0;
    a   = is_forward_rs ? rs_forward : rs_id;
    b   = is_forward_rt ? rt_forward : rt_id;
    sx  = {{16{imm[15]}}, imm};
    zx  = {16'h0, imm};
    pc4 = pc + 4;
    v   = 0;
    dst = 0;
    wb  = 0;
    ok  = 1;
    if (halt_in || i_type == 2'b11) begin
      o.halt = halt_in;
      return o;
    end
    case (opcode)
      6'h00: begin
        wb = 1; dst = rd;
        case (funct)
          6'h20, 6'h21: v = a + b;
          6'h22, 6'h23: v = a - b;
          6'h24: v = a & b;
          6'h25: v = a | b;
          6'h26: v = a ^ b;
          6'h27: v = ~(a | b);
          6'h2A: v = ($signed(a) < $signed(b)) ? 1 : 0;
          6'h2B: v = (a < b) ? 1 : 0;
          6'h00: v = b << sa;
          6'h02: v = b >> sa;
          6'h03: v = $signed(b) >>> sa;
          6'h04: v = b << a[4:0];
          6'h06: v = b >> a[4:0];
          6'h07: v = $signed(b) >>> a[4:0];
          6'h08: begin wb = 0; o.is_jump = 1; o.jump_address = a; end
          6'h09: begin o.is_jump = 1; o.jump_address = a; v = pc + 8; end
          default: ok = 0;
        endcase
      end
      6'h01, 6'h04, 6'h05, 6'h06, 6'h07: begin
        bit t;
        t = 0;
        case (opcode)
          6'h01: if (bltz == 0) t = $signed(a) < 0;
                 else if (bltz == 1) t = $signed(a) >= 0;
                 else ok = 0;
          6'h04: t = (a == b);
          6'h05: t = (a != b);
          6'h06: t = $signed(a) <= 0;
          default: t = $signed(a) > 0;
        endcase
        if (t) begin
          o.is_jump = 1;
          o.jump_address = pc4 + sx * 4;
        end
      end
      6'h02, 6'h03: begin
        o.is_jump = 1;
        o.jump_address = {pc4[31:28], offset, 2'b00};
        if (opcode == 6'h03) begin wb = 1; dst = 31; v = pc + 8; end
      end
      6'h08, 6'h09: begin wb = 1; dst = rt; v = a + sx; end
      6'h0A: begin wb = 1; dst = rt; v = ($signed(a) < $signed(sx)) ? 1 : 0; end
      6'h0B: begin wb = 1; dst = rt; v = (a < sx) ? 1 : 0; end
      6'h0C: begin wb = 1; dst = rt; v = a & zx; end
      6'h0D: begin wb = 1; dst = rt; v = a | zx; end
      6'h0E: begin wb = 1; dst = rt; v = a ^ zx; end
      6'h0F: begin wb = 1; dst = rt; v = {imm, 16'h0}; end
      6'h20, 6'h21, 6'h23: begin
        wb = 1; dst = rt; v = 0;
        o.is_mem = 1;
        o.effective_address = a + sx;
        o.data_width = (opcode == 6'h20) ? 2'd0 : (opcode == 6'h21) ? 2'd1 : 2'd2;
      end
      6'h28, 6'h29, 6'h2B: begin
        o.is_mem = 1;
        o.effective_address = a + sx;
        o.value_to_be_store = b;
        o.data_width = (opcode == 6'h28) ? 2'd0 : (opcode == 6'h29) ? 2'd1 : 2'd2;
      end
      default: ok = 0;
    endcase
    if (!ok) return '0;
    if (wb) begin
      o.int_wb_address = {1'b0, dst};
      o.int_wb_value   = v;
      o.is_int_wb      = (dst != 0);
    end
    return o;
  endfunction

  // Pipeline-register model: inputs change only after posedge, so these reads are stable.
  always @(posedge clk) begin
    if (!reset)                 exp_o = '0;
    else if (!halt_from_control) exp_o = ref_model();
    check_en = 1'b1;
  end

  always @(negedge clk) begin
    if (check_en) begin
      n_checks++;
      if (dut_o !== exp_o) begin
        n_fails++;
        $display("FAIL cycle_compare t=%0t actual=%h required=%h", $time, dut_o, exp_o);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    opcode = 0; format = 0; funct = 0; rs = 0; rt = 0; rd = 0; imm = 0;
    offset = 0; base = 0; sa = 0; bltz = 0; pc = 0; i_type = 0;
    rs_id = 0; rt_id = 0; rs_forward = 0; rt_forward = 0;
    is_forward_rs = 0; is_forward_rt = 0; halt_in = 0; halt_from_control = 0;
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'd4;
      default: return $urandom;
    endcase
  endfunction

  logic [5:0] ops [22] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                           6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                           6'h20, 6'h21, 6'h23, 6'h28, 6'h29, 6'h2B};
  logic [5:0] fns [18] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
                           6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                           6'h2A, 6'h2B};

  initial begin
    clear_inputs();
    // Reset with an ADDU already on the inputs.
    reset = 0; funct = 6'h21; rs_id = 5; rt_id = 7; rd = 3;
    tick();
    chk("reset_wb_value", int_wb_value, 0);
    chk("reset_is_int_wb", {31'd0, is_int_wb}, 0);
    reset = 1;
    tick();
    chk("addu_value", int_wb_value, 12);
    chk("addu_addr", {26'd0, int_wb_address}, 3);
    chk("addu_wb", {31'd0, is_int_wb}, 1);

    clear_inputs();
    opcode = 6'h09; rt = 4; is_forward_rs = 1; rs_forward = 100; rs_id = 1; imm = 16'hFFFF;
    tick();
    chk("fwd_addiu", int_wb_value, 99);

    clear_inputs();
    opcode = 6'h04; pc = 10000; rs_id = 4; rt_id = 4; imm = 3;
    tick();
    chk("beq_taken", {31'd0, is_jump}, 1);
    chk("beq_target", jump_address, 10016);
    rt_id = 5;
    tick();
    chk("beq_not_taken", {31'd0, is_jump}, 0);
    chk("beq_nt_addr", jump_address, 0);

    clear_inputs();
    opcode = 6'h03; pc = 32'h0040_0000; offset = 26'h10;
    tick();
    chk("jal_target", jump_address, 32'h40);
    chk("jal_addr", {26'd0, int_wb_address}, 31);
    chk("jal_link", int_wb_value, 32'h0040_0008);

    clear_inputs();
    opcode = 6'h2B; rs_id = 10100; imm = 16'hFFFC; rt_id = 32'hDEAD_BEEF; rt = 9;
    tick();
    chk("sw_ea", effective_address, 10096);
    chk("sw_mem", {31'd0, is_mem}, 1);
    chk("sw_no_wb", {31'd0, is_int_wb}, 0);
    chk("sw_width", {30'd0, data_width}, 2);
    chk("sw_data", value_to_be_store, 32'hDEAD_BEEF);
    opcode = 6'h20;
    tick();
    chk("lb_width", {30'd0, data_width}, 0);
    chk("lb_wb", {31'd0, is_int_wb}, 1);

    clear_inputs();
    funct = 6'h21; rs_id = 1; rt_id = 1; rd = 7; halt_from_control = 1;
    tick();
    tick();
    chk("stall_width", {30'd0, data_width}, 0);
    chk("stall_wb", {31'd0, is_int_wb}, 1);
    chk("stall_ea", effective_address, 10096);
    halt_from_control = 0; halt_in = 1;
    tick();
    chk("halt_flag", {31'd0, halt}, 1);
    chk("halt_enables", {29'd0, is_int_wb, is_mem, is_jump}, 0);
    halt_in = 0; reset = 0; halt_from_control = 1;
    tick();
    chk("reset_over_stall", {31'd0, halt}, 0);
    reset = 1; halt_from_control = 0;
    tick();
    chk("post_reset_addu", int_wb_value, 2);

    for (int i = 0; i < 3000; i++) begin
      reset             = ($urandom_range(0, 49) != 0);
      halt_from_control = ($urandom_range(0, 9) == 0);
      halt_in           = ($urandom_range(0, 14) == 0);
      i_type            = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      opcode            = ($urandom_range(0, 19) == 0) ? 6'($urandom) : ops[$urandom_range(0, 21)];
      funct             = ($urandom_range(0, 19) == 0) ? 6'($urandom) : fns[$urandom_range(0, 17)];
      format            = 5'($urandom);
      rs                = 5'($urandom);
      base              = rs;
      rt                = 5'($urandom);
      rd                = 5'($urandom);
      sa                = 5'($urandom);
      bltz              = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 1));
      imm               = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      offset            = 26'($urandom);
      pc                = {$urandom, 2'b00} >> 2 << 2;
      rs_id             = pick_val();
      rt_id             = ($urandom_range(0, 3) == 0) ? rs_id : pick_val();
      rs_forward        = pick_val();
      rt_forward        = pick_val();
      is_forward_rs     = 1'($urandom);
      is_forward_rt     = 1'($urandom);
      tick();
    end

    clear_inputs();
    reset = 1;
    tick();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
